// File: rtl/top.sv
// Single-precision FP unit: add/sub/mul/flt/sgnj in 2 cycles, iterative div/sqrt in 6 cycles.
// Define TOP_FSQRT_EN to build the square-root datapath; otherwise fsqrt returns qNaN after 2 cycles.
//
// state | meaning
// IDLE  | waiting for a request
// EXEC  | short op: result computed into res_q
// ITER  | div/sqrt: 5 quotient/root bits per cycle
// FIN   | drive y/ovf and pulse out_valid
module top (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  opcode,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf,
  output logic        out_valid
);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [2:0]  OP_ADD  = 3'd0;
  localparam logic [2:0]  OP_SUB  = 3'd1;
  localparam logic [2:0]  OP_MUL  = 3'd2;
  localparam logic [2:0]  OP_DIV  = 3'd3;
  localparam logic [2:0]  OP_SQRT = 3'd4;
  localparam logic [2:0]  OP_FLT  = 3'd5;
  localparam logic [2:0]  OP_SGNJ = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_FIN} state_t;

  state_t      state_q, state_d;
  logic        accept, exec_en, iter_en, fin_en;
  logic        req_valid, req_long, long_op;
  logic [2:0]  req_op, op_q, cnt_q;
  logic [31:0] a_q, b_q, res_q;
  logic        res_ovf_q;
  logic [24:0] q_q;
  logic [27:0] rem_q;
  logic [23:0] x1m;

  function automatic logic [32:0] pack(input logic s, input logic [9:0] e, input logic [22:0] f);
    if (e[9] || e == 10'd0)
      pack = {1'b0, s, 31'd0};
    else if (e >= 10'd255)
      pack = {1'b1, s, 8'hFF, 23'd0};
    else
      pack = {1'b0, s, e[7:0], f};
  endfunction

  always_comb begin
    req_valid = 1'b0;
    req_op    = OP_ADD;
    for (int i = 6; i >= 0; i--) begin
      if (opcode[i]) begin
        req_valid = 1'b1;
        req_op    = 3'(i);
      end
    end
  end

`ifdef TOP_FSQRT_EN
  assign req_long = (req_op == OP_DIV) || (req_op == OP_SQRT);
  assign long_op  = (op_q == OP_DIV) || (op_q == OP_SQRT);
`else
  assign req_long = (req_op == OP_DIV);
  assign long_op  = (op_q == OP_DIV);
`endif

  always_ff @(posedge clk) begin
    if (rstn) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = req_long ? S_ITER : S_EXEC;
      S_EXEC:  state_d = S_FIN;
      S_ITER:  if (cnt_q == 3'd0) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept  = (state_q == S_IDLE) && req_valid;
    exec_en = (state_q == S_EXEC);
    iter_en = (state_q == S_ITER);
    fin_en  = (state_q == S_FIN);
  end

  // Unpacked operands; denormals flush to zero through a zero mantissa.
  logic        sa, sb, za, zb, na, nb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  assign sa = a_q[31];
  assign sb = b_q[31];
  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign za = (ea == 8'd0);
  assign zb = (eb == 8'd0);
  assign na = (ea == 8'hFF);
  assign nb = (eb == 8'hFF);
  assign ma = za ? 24'd0 : {1'b1, a_q[22:0]};
  assign mb = zb ? 24'd0 : {1'b1, b_q[22:0]};
  assign x1m = (x1[30:23] == 8'd0) ? 24'd0 : {1'b1, x1[22:0]};

  // Add/sub: 24 guard bits keep alignment exact up to a 24-bit shift; beyond that a sticky bit
  // keeps the truncated subtraction from rounding up.
  logic        sb_eff, sg, ss;
  logic [7:0]  eg, es, d;
  logic [23:0] mg, ms;
  logic [48:0] wide_g, wide_s, sum, norm;
  logic [5:0]  lz;
  logic [9:0]  add_exp;
  always_comb begin
    sb_eff = sb ^ (op_q == OP_SUB);
    if ({ea, ma[22:0]} >= {eb, mb[22:0]}) begin
      sg = sa; eg = ea; mg = ma; ss = sb_eff; es = eb; ms = mb;
    end else begin
      sg = sb_eff; eg = eb; mg = mb; ss = sa; es = ea; ms = ma;
    end
    d         = eg - es;
    wide_g    = {1'b0, mg, 24'd0};
    wide_s    = {1'b0, ({ms, 24'd0} >> d)};
    wide_s[0] = wide_s[0] | ((d > 8'd24) && (ms != 24'd0));
    sum       = (sg != ss) ? (wide_g - wide_s) : (wide_g + wide_s);
    lz        = 6'd0;
    for (int i = 0; i < 49; i++)
      if (sum[i]) lz = 6'(48 - i);
    norm    = sum << lz;
    add_exp = {2'b00, eg} + 10'd1 - {4'd0, lz};
  end

  logic [47:0] prod;
  logic [9:0]  mul_exp;
  assign prod    = {24'd0, ma} * {24'd0, mb};
  assign mul_exp = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} - 10'd127;

  logic        flt_sa, flt_sb, flt_lt;
  logic [30:0] ka, kb;
  always_comb begin
    flt_sa = za ? 1'b0 : sa;
    flt_sb = zb ? 1'b0 : sb;
    ka     = za ? 31'd0 : a_q[30:0];
    kb     = zb ? 31'd0 : b_q[30:0];
    if (flt_sa != flt_sb) flt_lt = flt_sa;
    else if (flt_sa)      flt_lt = (ka > kb);
    else                  flt_lt = (ka < kb);
  end

  logic [32:0] simple_res;
  always_comb begin
    simple_res = {1'b0, QNAN};
    case (op_q)
      OP_ADD, OP_SUB: begin
        if (na || nb)          simple_res = {1'b0, QNAN};
        else if (sum == 49'd0) simple_res = 33'd0;
        else                   simple_res = pack(sg, add_exp, norm[47:25]);
      end
      OP_MUL: begin
        if (na || nb)      simple_res = {1'b0, QNAN};
        else if (za || zb) simple_res = {1'b0, sa ^ sb, 31'd0};
        else simple_res = pack(sa ^ sb, mul_exp, prod[47] ? prod[46:24] : prod[45:23]);
      end
      OP_FLT: begin
        if (na || nb) simple_res = {1'b0, QNAN};
        else          simple_res = {32'd0, flt_lt};
      end
      OP_SGNJ: simple_res = {1'b0, b_q[31], a_q[30:0]};
      default: simple_res = {1'b0, QNAN};
    endcase
  end

  // Restoring divide: 25 quotient bits, integer bit first.
  logic [27:0] div_rem;
  logic [24:0] div_q;
  always_comb begin
    div_rem = rem_q;
    div_q   = q_q;
    for (int k = 0; k < 5; k++) begin
      if (div_rem >= {4'd0, mb}) begin
        div_rem = div_rem - {4'd0, mb};
        div_q   = {div_q[23:0], 1'b1};
      end else begin
        div_q   = {div_q[23:0], 1'b0};
      end
      div_rem = {div_rem[26:0], 1'b0};
    end
  end

  logic [9:0]  div_exp;
  logic [32:0] iter_res;
  assign div_exp = {2'b00, ea} - {2'b00, eb} + 10'd126 + {9'd0, q_q[24]};

`ifdef TOP_FSQRT_EN
  logic [49:0] rad_q, sq_rad;
  logic [27:0] sq_rem, sq_trial;
  logic [24:0] sq_q;
  logic [7:0]  sqrt_exp;
  logic [24:0] x1_rad;
  always_comb begin
    sq_rem = rem_q;
    sq_q   = q_q;
    sq_rad = rad_q;
    for (int k = 0; k < 5; k++) begin
      sq_rem   = {sq_rem[25:0], sq_rad[49:48]};
      sq_rad   = {sq_rad[47:0], 2'b00};
      sq_trial = {1'b0, sq_q, 2'b01};
      if (sq_rem >= sq_trial) begin
        sq_rem = sq_rem - sq_trial;
        sq_q   = {sq_q[23:0], 1'b1};
      end else begin
        sq_q   = {sq_q[23:0], 1'b0};
      end
    end
  end
  // Odd unbiased exponent (even biased) doubles the radicand so the root exponent is exact.
  assign x1_rad   = x1[23] ? {1'b0, x1m} : {x1m, 1'b0};
  assign sqrt_exp = {1'b0, ea[7:1]} + 8'd63 + {7'd0, ea[0]};
`endif

  always_comb begin
    iter_res = {1'b0, QNAN};
`ifdef TOP_FSQRT_EN
    if (op_q == OP_SQRT) begin
      if (na)      iter_res = {1'b0, QNAN};
      else if (za) iter_res = {1'b0, sa, 31'd0};
      else if (sa) iter_res = {1'b0, QNAN};
      else         iter_res = {2'b00, sqrt_exp, q_q[23:1]};
    end else
`endif
    begin
      if (na || nb)  iter_res = {1'b0, QNAN};
      else if (zb)   iter_res = za ? {1'b0, QNAN} : {1'b1, sa ^ sb, 8'hFF, 23'd0};
      else if (za)   iter_res = {1'b0, sa ^ sb, 31'd0};
      else iter_res = pack(sa ^ sb, div_exp, q_q[24] ? q_q[23:1] : q_q[22:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      op_q      <= OP_ADD;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      cnt_q     <= 3'd0;
      q_q       <= 25'd0;
      rem_q     <= 28'd0;
`ifdef TOP_FSQRT_EN
      rad_q     <= 50'd0;
`endif
      res_q     <= 32'd0;
      res_ovf_q <= 1'b0;
      y         <= 32'd0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= fin_en;
      if (accept) begin
        op_q  <= req_op;
        a_q   <= x1;
        b_q   <= x2;
        cnt_q <= 3'd4;
        q_q   <= 25'd0;
`ifdef TOP_FSQRT_EN
        rem_q <= (req_op == OP_SQRT) ? 28'd0 : {4'd0, x1m};
        rad_q <= {x1_rad, 25'd0};
`else
        rem_q <= {4'd0, x1m};
`endif
      end
      if (iter_en) begin
        if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
`ifdef TOP_FSQRT_EN
        if (op_q == OP_SQRT) begin
          q_q   <= sq_q;
          rem_q <= sq_rem;
          rad_q <= sq_rad;
        end else begin
          q_q   <= div_q;
          rem_q <= div_rem;
        end
`else
        q_q   <= div_q;
        rem_q <= div_rem;
`endif
      end
      if (exec_en) begin
        res_q     <= simple_res[31:0];
        res_ovf_q <= simple_res[32];
      end
      if (fin_en) begin
        if (long_op) begin
          y   <= iter_res[31:0];
          ovf <= iter_res[32];
        end else begin
          y   <= res_q;
          ovf <= res_ovf_q;
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{opcode[7], norm[48], norm[24:0], prod[22:0]};

endmodule

// File: tb/tb_top.sv
// Directed bench for top: hand-computed vectors for each op, latency, busy and reset behaviour.
module tb_top;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  opcode;
  logic [31:0] x1, x2;
  logic [31:0] y;
  logic        ovf, out_valid;

  int checks = 0;
  int errors = 0;

  top dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .x1(x1), .x2(x2),
    .y(y), .ovf(ovf), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(inout int lat);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_y, input logic exp_ovf,
                        input int exp_lat);
    int lat;
    @(negedge clk);
    opcode = op; x1 = a; x2 = b;
    @(posedge clk); #1;
    opcode = 8'h00;
    lat = 0;
    wait_valid(lat);
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_y"}, y, exp_y);
    check_val({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_hold"}, y, exp_y);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check_val(tag, 32'(pulses), 32'd0);
  endtask

  localparam logic [7:0] ADD = 8'h01, SUB = 8'h02, MUL = 8'h04, DIV = 8'h08;
  localparam logic [7:0] SQRT = 8'h10, FLT = 8'h20, SGNJ = 8'h40;
  localparam logic [31:0] NAN = 32'h7FC0_0000;

`ifdef TOP_FSQRT_EN
  localparam int SQ_LAT = 6;
  localparam logic [31:0] SQ4 = 32'h4000_0000;
  localparam logic [31:0] SQ2 = 32'h3FB5_04F3;
`else
  localparam int SQ_LAT = 2;
  localparam logic [31:0] SQ4 = 32'h7FC0_0000;
  localparam logic [31:0] SQ2 = 32'h7FC0_0000;
`endif

  initial begin
    int lat;
    rstn = 1'b1; opcode = 8'h00; x1 = 32'd0; x2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_y", y, 32'd0);
    check_val("rst_ovf", {31'd0, ovf}, 32'd0);
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b0;

    run_op("fadd",      ADD,  32'h44FA21B3, 32'h44FA40F8, 32'h457A3155, 1'b0, 2);
    run_op("fsub",      SUB,  32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 2);
    run_op("fsub_zero", SUB,  32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 2);
    run_op("fadd_neg",  ADD,  32'hC0000000, 32'h3F800000, 32'hBF800000, 1'b0, 2);
    run_op("fadd_trunc",ADD,  32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 2);
    run_op("fsub_trunc",SUB,  32'h3F800000, 32'h33000000, 32'h3F7FFFFF, 1'b0, 2);
    run_op("fadd_den",  ADD,  32'h00400000, 32'h3F800000, 32'h3F800000, 1'b0, 2);
    run_op("fadd_ovf",  ADD,  32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 2);
    run_op("fadd_nan",  ADD,  32'h7F800000, 32'h3F800000, NAN,          1'b0, 2);
    run_op("fmul",      MUL,  32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 2);
    run_op("fmul_ovf",  MUL,  32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 2);
    run_op("fmul_neg",  MUL,  32'hC0000000, 32'h3FC00000, 32'hC0400000, 1'b0, 2);
    run_op("fmul_unf",  MUL,  32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 2);
    run_op("fdiv",      DIV,  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 6);
    run_op("fdiv_third",DIV,  32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 6);
    run_op("fdiv_dz",   DIV,  32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 6);
    run_op("fdiv_00",   DIV,  32'h00000000, 32'h00000000, NAN,          1'b0, 6);
    run_op("fsqrt4",    SQRT, 32'h40800000, 32'h00000000, SQ4,          1'b0, SQ_LAT);
    run_op("fsqrt2",    SQRT, 32'h40000000, 32'h00000000, SQ2,          1'b0, SQ_LAT);
    run_op("fsqrt_neg", SQRT, 32'hBF800000, 32'h00000000, NAN,          1'b0, SQ_LAT);
    run_op("flt_lt",    FLT,  32'h3F800000, 32'h40000000, 32'h00000001, 1'b0, 2);
    run_op("flt_ge",    FLT,  32'h40000000, 32'h3F800000, 32'h00000000, 1'b0, 2);
    run_op("flt_zeros", FLT,  32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 2);
    run_op("flt_mixed", FLT,  32'hBF800000, 32'h3F000000, 32'h00000001, 1'b0, 2);
    run_op("flt_negs",  FLT,  32'hC0000000, 32'hBF800000, 32'h00000001, 1'b0, 2);
    run_op("fsgnj",     SGNJ, 32'h3FD61587, 32'hBF561E83, 32'hBFD61587, 1'b0, 2);
    run_op("prio",      8'h06,32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 2);

    // Reserved bit alone is idle.
    @(negedge clk);
    opcode = 8'h80; x1 = 32'h3F800000; x2 = 32'h3F800000;
    @(posedge clk); #1;
    opcode = 8'h00;
    expect_quiet("bit7_idle", 8);

    // fmul presented while fdiv is busy must be dropped.
    @(negedge clk);
    opcode = DIV; x1 = 32'h40C00000; x2 = 32'h40000000;
    @(posedge clk); #1;
    opcode = MUL; x1 = 32'h40000000; x2 = 32'h40400000;
    @(posedge clk); #1;
    opcode = 8'h00;
    lat = 1;
    wait_valid(lat);
    check_val("busy_lat", 32'(lat), 32'd6);
    check_val("busy_y", y, 32'h40400000);
    expect_quiet("busy_quiet", 10);

    // Reset mid-fdiv, with a request held during reset; first accept on the release edge.
    @(negedge clk);
    opcode = DIV; x1 = 32'h40C00000; x2 = 32'h40000000;
    @(posedge clk); #1;
    opcode = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1; opcode = ADD; x1 = 32'h3F800000; x2 = 32'h3F800000;
    @(posedge clk); #1;
    check_val("mid_rst_y", y, 32'd0);
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b0; opcode = MUL; x1 = 32'h40000000; x2 = 32'h40400000;
    @(posedge clk); #1;
    opcode = 8'h00;
    lat = 0;
    wait_valid(lat);
    check_val("post_rst_lat", 32'(lat), 32'd2);
    check_val("post_rst_y", y, 32'h40C00000);
    expect_quiet("post_rst_quiet", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: reset, synchronous, active-high (rstn=1 resets).
REQ-003 SHALL have port opcode, input, 8 bits, one-hot operation request:
- bit0 fadd
- bit1 fsub
- bit2 fmul
- bit3 fdiv
- bit4 fsqrt(x1)
- bit5 flt
- bit6 fsgnj
- bit7 reserved
- 0 = idle
REQ-004 SHALL have port x1, input, 32 bits: IEEE-754 single operand A.
REQ-005 SHALL have port x2, input, 32 bits: IEEE-754 single operand B.
REQ-006 SHALL have port y, output, 32 bits: result.
REQ-007 SHALL have port ovf, output, 1 bit: overflow/div-by-zero flag, valid with out_valid.
REQ-008 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking y/ovf valid.

Function
REQ-009 SHALL accept an operation in any cycle where opcode≠0 and the unit is idle, sampling x1, x2 and opcode in that cycle.
REQ-010 SHALL, when several opcode bits are set, execute the lowest-numbered set bit.
- bit7 alone: treated as idle.
REQ-011 SHALL ignore opcode while busy; no queueing.
REQ-012 SHALL assert out_valid exactly 2 cycles after the accept edge for fadd/fsub/fmul/flt/fsgnj.
REQ-013 SHALL assert out_valid exactly 6 cycles after the accept edge for fdiv/fsqrt.
- Iterative mantissa datapath, 5 quotient/root bits per cycle.
REQ-014 SHALL hold y and ovf stable from each out_valid until the next out_valid.
REQ-015 SHALL compute fadd = x1+x2 and fsub = x1−x2, with 24-bit alignment, normalization, exponent adjust.
REQ-016 SHALL compute fmul with a 24x24 mantissa product, normalized.
REQ-017 SHALL compute fdiv = x1/x2 and fsqrt = sqrt(x1).
REQ-018 SHALL round all arithmetic results toward zero (truncate).
REQ-019 SHALL flush denormal inputs and denormal results to signed zero.
REQ-020 SHALL, on exponent overflow, return y = sign|0x7F800000 with ovf=1.
- ovf=0 for all non-overflowing results.
REQ-021 SHALL, for fdiv with x2=±0 and x1≠0, return signed infinity with ovf=1.
REQ-022 SHALL, for fdiv with 0/0, return y=0x7FC00000 with ovf=0.
REQ-023 SHALL return y=0x7FC00000, ovf=0 for any operand with exponent 255.
REQ-024 SHALL return y=0x7FC00000, ovf=0 for fsqrt of negative nonzero x1.
REQ-025 SHALL return +0 for an exact-zero sum.
REQ-026 SHALL compute flt: y=0x00000001 if x1<x2 numerically, else 0.
- +0 and −0 compare equal.
REQ-027 SHALL compute fsgnj: y = {x2[31], x1[30:0]}, with ovf=0.

Reset
REQ-028 SHALL, on rstn=1 at a clock edge, force y=0x00000000, ovf=0, out_valid=0, and return to idle.
- Any in-flight operation is discarded.
REQ-029 SHALL ignore opcode in any cycle where rstn=1.
- The first accept is possible on the first edge with rstn=0.

Configuration
REQ-030 SHALL, with macro TOP_FSQRT_EN defined, implement fsqrt per REQ-013/REQ-017.
REQ-031 SHALL, without TOP_FSQRT_EN, accept fsqrt, return y=0x7FC00000 with ovf=0 after 2 cycles, and contain no square-root datapath.

Verification
REQ-032 SHALL check fadd: x1=0x44FA21B3, x2=0x44FA40F8 -> y=0x457A3155, ovf=0, out_valid 2 cycles after accept.
REQ-033 SHALL check fmul: 0x40000000 × 0x40400000 -> y=0x40C00000.
- Also: 0x7F000000 × 0x40000000 -> y=0x7F800000, ovf=1.
REQ-034 SHALL check fdiv: 0x40C00000 / 0x40000000 -> y=0x40400000 at 6 cycles.
- Also: 0x3F800000 / 0x00000000 -> y=0x7F800000, ovf=1.
REQ-035 SHALL check fsqrt: x1=0x40800000 -> y=0x40000000 at 6 cycles.
- Also: x1=0xBF800000 -> y=0x7FC00000.
REQ-036 SHALL check flt and fsgnj:
- flt 0x3F800000 < 0x40000000 -> y=1.
- fsgnj x1=0x3FD61587, x2=0xBF561E83 -> y=0xBFD61587.
REQ-037 SHALL check busy/reset behavior:
- fmul issued 1 cycle after an fdiv accept is ignored; only the fdiv result appears.
- rstn=1 mid-fdiv -> no out_valid, y=0.
